// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter: FSM state encoding, grant
// codes, idle bus address and beat count for the 32-bit <-> 8-bit serialiser.
package mem_bus_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_BEAT = 3'd1,
        ST_RD_TAIL = 3'd2,
        ST_WR_BEAT = 3'd3,
        ST_ACK     = 3'd4
    } state_e;

    typedef enum logic {
        GRANT_IF = 1'b0,
        GRANT_DM = 1'b1
    } grant_e;

    localparam logic [7:0] IDLE_ADDR = 8'hFF;
    localparam int         BEATS     = 4;
    localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

    // Word requests are always word aligned; low address bits are ignored.
    function automatic logic [7:0] word_base(input logic [7:0] a);
        return {a[7:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_word_serdes.sv
// Word serialiser/deserialiser for the byte bus.
//   clk_i, rst_ni : clock, async active-low reset
//   load_i        : load wdata_i into the word register (at grant)
//   wdata_i       : store word
//   rd_i          : read beat issued this cycle (bus_rd)
//   cnt_en_i      : advance beat counter; counter clears when low
//   data_in_i     : external read byte
//   cnt_o         : current beat index
//   word_o        : assembled / store word
//   byte_o        : byte lane of word_o selected by the beat counter
module mem_bus_arbiter_word_serdes
    import mem_bus_arbiter_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic [31:0] wdata_i,
    input  logic        rd_i,
    input  logic        cnt_en_i,
    input  logic [7:0]  data_in_i,
    output logic [1:0]  cnt_o,
    output logic [31:0] word_o,
    output logic [7:0]  byte_o
);

    logic [1:0]          cnt_q, cnt_d;
    logic [8*BEATS-1:0]  word_q, word_d;
    logic [RD_LAT-1:0]   rd_pipe_q;
    logic [RD_LAT:0]     rd_pipe;

    // rd_pipe[k] is the read strobe delayed by k cycles; the top bit marks the
    // cycle in which the byte for an earlier beat is present on data_in.
    assign rd_pipe = {rd_pipe_q, rd_i};

    always_comb begin
        cnt_d  = cnt_en_i ? cnt_q + 2'd1 : 2'd0;
        word_d = word_q;
        if (load_i) begin
            word_d = wdata_i;
        end else if (rd_pipe[RD_LAT]) begin
            // LSB-first beats: shifting right leaves beat 0 in lane 0 after 4 bytes.
            word_d = {data_in_i, word_q[31:8]};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= 2'd0;
            word_q    <= '0;
            rd_pipe_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            word_q    <= word_d;
            rd_pipe_q <= rd_pipe[RD_LAT-1:0];
        end
    end

    assign cnt_o  = cnt_q;
    assign word_o = word_q;
    assign byte_o = word_q[{cnt_q, 3'b000} +: 8];

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the 8-bit external byte bus between the instruction-fetch and
// data-memory ports, moving whole 32-bit words as 4 LSB-first byte beats.
//   clk_i, rst_ni            : clock, async active-low reset
//   if_req_i / if_addr_i     : fetch request (level) and word address
//   if_ack_o / if_rdata_o    : fetch done pulse, fetched word
//   dm_req_i, dm_we_i        : data request (level), store select
//   dm_addr_i, dm_wdata_i    : data word address, store data
//   dm_ack_o / dm_rdata_o    : data done pulse, loaded word
//   data_in_i / data_out_o   : external read / write byte
//   address_out_o            : external byte address, 0xFF when idle
//   bus_rd_o / bus_we_o      : read / write beat qualifiers
//   busy_o                   : transaction in progress
module mem_bus_arbiter #(
    parameter int RD_LAT       = 1,
    parameter int MAX_DM_BURST = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        if_req_i,
    input  logic [7:0]  if_addr_i,
    output logic        if_ack_o,
    output logic [31:0] if_rdata_o,
    input  logic        dm_req_i,
    input  logic        dm_we_i,
    input  logic [7:0]  dm_addr_i,
    input  logic [31:0] dm_wdata_i,
    output logic        dm_ack_o,
    output logic [31:0] dm_rdata_o,
    input  logic [7:0]  data_in_i,
    output logic [7:0]  data_out_o,
    output logic [7:0]  address_out_o,
    output logic        bus_rd_o,
    output logic        bus_we_o,
    output logic        busy_o
);
    import mem_bus_arbiter_pkg::*;

    localparam int         SW        = $clog2(MAX_DM_BURST + 1);
    localparam logic [1:0] TAIL_LAST = 2'(RD_LAT - 1);

    state_e          state_q, state_d;
    grant_e          grant_q, grant_d;
    logic            we_q, we_d;
    logic [7:0]      addr_q, addr_d;
    logic [SW-1:0]   streak_q, streak_d;
    logic [31:0]     if_rdata_q, dm_rdata_q;

    logic            load, cnt_en;
    logic [1:0]      cnt;
    logic [31:0]     word;
    logic [7:0]      lane_byte;

    mem_bus_arbiter_word_serdes #(.RD_LAT(RD_LAT)) u_serdes (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .load_i    (load),
        .wdata_i   (dm_wdata_i),
        .rd_i      (bus_rd_o),
        .cnt_en_i  (cnt_en),
        .data_in_i (data_in_i),
        .cnt_o     (cnt),
        .word_o    (word),
        .byte_o    (lane_byte)
    );

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        we_d     = we_q;
        addr_d   = addr_q;
        streak_d = streak_q;
        load     = 1'b0;
        cnt_en   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // Data port has priority until it has won MAX_DM_BURST times
                // in a row over a waiting fetch.
                if (dm_req_i && !(if_req_i && streak_q == SW'(MAX_DM_BURST))) begin
                    grant_d  = GRANT_DM;
                    we_d     = dm_we_i;
                    addr_d   = word_base(dm_addr_i);
                    load     = 1'b1;
                    streak_d = if_req_i ? streak_q + SW'(1) : '0;
                    state_d  = dm_we_i ? ST_WR_BEAT : ST_RD_BEAT;
                end else if (if_req_i) begin
                    grant_d  = GRANT_IF;
                    we_d     = 1'b0;
                    addr_d   = word_base(if_addr_i);
                    load     = 1'b1;
                    streak_d = '0;
                    state_d  = ST_RD_BEAT;
                end else begin
                    streak_d = '0;
                end
            end
            ST_RD_BEAT: begin
                cnt_en = 1'b1;
                if (cnt == LAST_BEAT) state_d = ST_RD_TAIL;
            end
            ST_RD_TAIL: begin
                // Counter restarted from 0 on the last beat's wrap; reuse it
                // to wait out the read latency.
                cnt_en = 1'b1;
                if (cnt == TAIL_LAST) state_d = ST_ACK;
            end
            ST_WR_BEAT: begin
                cnt_en = 1'b1;
                if (cnt == LAST_BEAT) state_d = ST_ACK;
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            grant_q    <= GRANT_IF;
            we_q       <= 1'b0;
            addr_q     <= 8'h00;
            streak_q   <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            streak_q <= streak_d;
            if (if_ack_o)             if_rdata_q <= word;
            if (dm_ack_o && !we_q)    dm_rdata_q <= word;
        end
    end

    assign bus_rd_o      = (state_q == ST_RD_BEAT);
    assign bus_we_o      = (state_q == ST_WR_BEAT);
    assign busy_o        = (state_q != ST_IDLE);
    assign address_out_o = (bus_rd_o || bus_we_o) ? addr_q + {6'b0, cnt} : IDLE_ADDR;
    assign data_out_o    = bus_we_o ? lane_byte : 8'h00;
    assign if_ack_o      = (state_q == ST_ACK) && (grant_q == GRANT_IF);
    assign dm_ack_o      = (state_q == ST_ACK) && (grant_q == GRANT_DM);
    // The completed word is presented during the ack cycle itself.
    assign if_rdata_o    = if_ack_o ? word : if_rdata_q;
    assign dm_rdata_o    = (dm_ack_o && !we_q) ? word : dm_rdata_q;

endmodule
